// File: rtl/iob_pcie_tx_arb_if.sv
// Bundles the requester-side and channel-side signals of the PCIe TX arbiter.
// No logic here; all timing is set by the arbiter itself.
// master = arbiter side, slave = requesters plus channel (testbench side).
interface iob_pcie_tx_arb_if #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int NREQ             = 2
);
    logic [NREQ-1:0]                  REQ_TX;
    logic [NREQ*32-1:0]               REQ_LEN;
    logic [NREQ*31-1:0]               REQ_OFF;
    logic [NREQ-1:0]                  REQ_LAST;
    logic [NREQ*C_PCI_DATA_WIDTH-1:0] REQ_DATA;
    logic [NREQ-1:0]                  REQ_DATA_VALID;
    logic [NREQ-1:0]                  REQ_DATA_REN;
    logic [NREQ-1:0]                  REQ_GNT;
    logic [NREQ-1:0]                  REQ_DONE;
    logic                             CHNL_TX;
    logic                             CHNL_TX_ACK;
    logic                             CHNL_TX_LAST;
    logic [31:0]                      CHNL_TX_LEN;
    logic [30:0]                      CHNL_TX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0]      CHNL_TX_DATA;
    logic                             CHNL_TX_DATA_VALID;
    logic                             CHNL_TX_DATA_REN;

    modport master (
        input  REQ_TX, REQ_LEN, REQ_OFF, REQ_LAST, REQ_DATA, REQ_DATA_VALID,
        input  CHNL_TX_ACK, CHNL_TX_DATA_REN,
        output REQ_DATA_REN, REQ_GNT, REQ_DONE,
        output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
        output CHNL_TX_DATA, CHNL_TX_DATA_VALID
    );

    modport slave (
        output REQ_TX, REQ_LEN, REQ_OFF, REQ_LAST, REQ_DATA, REQ_DATA_VALID,
        output CHNL_TX_ACK, CHNL_TX_DATA_REN,
        input  REQ_DATA_REN, REQ_GNT, REQ_DONE,
        input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
        input  CHNL_TX_DATA, CHNL_TX_DATA_VALID
    );
endinterface

// File: rtl/iob_pcie_tx_arb.sv
// Round-robin arbiter sharing one PCIe TX channel among NREQ requesters.
// Latency: grant 1 cycle after request; data path is combinational in XFER.
// Backpressure: channel REN is passed straight to the granted requester only.
module iob_pcie_tx_arb #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int NREQ             = 2
) (
    input  logic CLK,
    input  logic RST_N,
    iob_pcie_tx_arb_if.master bus
);
    localparam int STEP = C_PCI_DATA_WIDTH / 32;
    localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [SELW-1:0]             sel_q, rr_q, pick;
    logic                        found;
    logic [31:0]                 cnt_q, len_q;
    logic [30:0]                 off_q;
    logic                        last_q;
    logic                        beat;
    logic [32:0]                 cnt_next;
    logic [31:0]                 len_arr  [NREQ];
    logic [30:0]                 off_arr  [NREQ];
    logic [C_PCI_DATA_WIDTH-1:0] data_arr [NREQ];

    // Unpack the flat per-requester buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            len_arr[i]  = bus.REQ_LEN[32*i +: 32];
            off_arr[i]  = bus.REQ_OFF[31*i +: 31];
            data_arr[i] = bus.REQ_DATA[C_PCI_DATA_WIDTH*i +: C_PCI_DATA_WIDTH];
        end
    end

    // Round-robin pick: first requesting slot at or above rr_q, wrapping.
    always_comb begin
        int              idx;
        logic [SELW-1:0] idx_w;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = SELW'(idx);
            if (!found && bus.REQ_TX[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

    // 33-bit compare so a length near 2^32 cannot wrap the word count.
    assign cnt_next = {1'b0, cnt_q} + 33'(STEP);
    assign beat     = (state_q == S_XFER) && bus.REQ_DATA_VALID[sel_q] && bus.CHNL_TX_DATA_REN;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and all outputs; every output is zero outside the granted slot.
    always_comb begin
        state_d                = state_q;
        bus.CHNL_TX            = 1'b0;
        bus.REQ_GNT            = '0;
        bus.REQ_DONE           = '0;
        bus.REQ_DATA_REN       = '0;
        bus.CHNL_TX_DATA       = '0;
        bus.CHNL_TX_DATA_VALID = 1'b0;
        bus.CHNL_TX_LEN        = len_q;
        bus.CHNL_TX_OFF        = off_q;
        bus.CHNL_TX_LAST       = last_q;
        case (state_q)
            S_IDLE: begin
                if (found) state_d = S_REQ;
            end
            S_REQ: begin
                bus.CHNL_TX        = 1'b1;
                bus.REQ_GNT[sel_q] = 1'b1;
                if (bus.CHNL_TX_ACK) state_d = (len_q == 32'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                bus.CHNL_TX                 = 1'b1;
                bus.REQ_GNT[sel_q]          = 1'b1;
                bus.REQ_DATA_REN[sel_q]     = bus.CHNL_TX_DATA_REN;
                bus.CHNL_TX_DATA            = data_arr[sel_q];
                bus.CHNL_TX_DATA_VALID      = bus.REQ_DATA_VALID[sel_q];
                if (beat && (cnt_next >= {1'b0, len_q})) state_d = S_DONE;
            end
            S_DONE: begin
                bus.REQ_GNT[sel_q]  = 1'b1;
                bus.REQ_DONE[sel_q] = 1'b1;
                state_d             = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Descriptor latch, word counter and round-robin pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_q  <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            off_q  <= '0;
            last_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        sel_q  <= pick;
                        len_q  <= len_arr[pick];
                        off_q  <= off_arr[pick];
                        last_q <= bus.REQ_LAST[pick];
                        cnt_q  <= '0;
                    end
                end
                S_XFER: begin
                    if (beat) cnt_q <= cnt_next[31:0];
                end
                S_DONE: begin
                    rr_q <= (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + SELW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iob_pcie_tx_arb.md
Name: iob_pcie_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one PCIe TX channel between NREQ local requesters.
- The channel is the CLK-domain CHNL_TX_* stream interface, with lengths in 32-bit words.
- Each requester presents a transfer descriptor (length, offset, last) plus a data stream.
- The block grants one requester at a time, runs the channel handshake on its behalf, counts words to completion, then moves priority on to the next requester.

Parameters:
- C_PCI_DATA_WIDTH, 32: channel data width in bits (32/64/128); STEP = C_PCI_DATA_WIDTH/32 words per beat.
- NREQ, 2: number of requesters, 2..8.

Ports:
- CLK  in  1  single clock for all logic and the channel.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ_TX  in  NREQ  per-requester transfer request (level).
- REQ_LEN  in  NREQ*32  per-requester length in words; slice i = [32*i+31:32*i].
- REQ_OFF  in  NREQ*31  per-requester offset.
- REQ_LAST  in  NREQ  per-requester last flag.
- REQ_DATA  in  NREQ*C_PCI_DATA_WIDTH  per-requester data.
- REQ_DATA_VALID  in  NREQ  per-requester data valid.
- REQ_DATA_REN  out  NREQ  per-requester data read-enable.
- REQ_GNT  out  NREQ  one-hot grant; high from descriptor latch through DONE.
- REQ_DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- CHNL_TX  out  1  channel transaction request.
- CHNL_TX_ACK  in  1  channel accepted the transaction.
- CHNL_TX_LAST  out  1  latched last flag.
- CHNL_TX_LEN  out  32  latched length.
- CHNL_TX_OFF  out  31  latched offset.
- CHNL_TX_DATA  out  C_PCI_DATA_WIDTH  data muxed from the granted requester.
- CHNL_TX_DATA_VALID  out  1  valid muxed from the granted requester.
- CHNL_TX_DATA_REN  in  1  channel read-enable.

Behaviour:
- Reset (RST_N low, async):
  - State IDLE, sel=0, rr_ptr=0, count=0, latched LEN/OFF/LAST=0.
  - All outputs 0.
- States: IDLE -> REQ -> XFER -> DONE -> IDLE.
- IDLE:
  - If any REQ_TX bit is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo NREQ.
  - Latch sel, LEN, OFF, LAST from that slice; clear count; go to REQ.
  - Grant decision takes 1 cycle after the request is seen.
- REQ:
  - CHNL_TX=1, REQ_GNT[sel]=1, CHNL_TX_LEN/OFF/LAST driven from the latched values.
  - Wait for CHNL_TX_ACK.
  - On ACK: go to XFER, or to DONE directly if latched LEN==0.
- XFER:
  - CHNL_TX stays 1.
  - CHNL_TX_DATA = REQ_DATA[sel] and CHNL_TX_DATA_VALID = REQ_DATA_VALID[sel], combinational.
  - REQ_DATA_REN[sel] = CHNL_TX_DATA_REN; REQ_DATA_REN is 0 for every other requester and in every other state.
  - A beat is when VALID and REN are both high; on a beat, count += STEP.
  - When a beat makes count+STEP >= LEN (the final beat may be partial), go to DONE.
  - count is 32 bits; comparison uses 33-bit arithmetic so no wrap occurs near 2^32.
- DONE:
  - CHNL_TX=0, REQ_DONE[sel]=1 for exactly 1 cycle, REQ_GNT still high.
  - rr_ptr = (sel+1) mod NREQ; go to IDLE.
  - The requester must drop REQ_TX on the DONE pulse. REQ_TX sampled in DONE is ignored. A REQ_TX still high in the following IDLE cycle is a new request.
- Descriptor changes:
  - Changes to REQ_LEN/OFF/LAST after the latch are ignored.
  - REQ_TX deassertion mid-transfer is ignored; the transfer runs to LEN.
- Simultaneous requests: rr_ptr decides. Minimum gap between back-to-back grants is 1 IDLE cycle.
- Non-granted requesters see REN=0, GNT=0, DONE=0 throughout.
- RST_N asserted mid-transfer:
  - Immediate return to IDLE with all outputs 0; the channel transaction is abandoned.
  - The channel side is reset together with this block.

Test Plan:
- C_PCI_DATA_WIDTH=64, NREQ=2; req0 LEN=8, CHNL_TX_DATA_REN always 1, valid always 1 -> 4 beats forwarded in order, REQ_DONE[0] pulses 1 cycle after the 4th beat, CHNL_TX low in DONE.
- REQ_TX=2'b11 held continuously, LEN=4 each -> grants alternate 0,1,0,1; each REQ_DONE pulses once per transfer; CHNL_TX_LEN matches the granted slice.
- LEN=5 with 64-bit data -> exactly 3 beats, then DONE; LEN=0 -> ACK leads straight to DONE with zero REN pulses.
- Random VALID and REN gaps, LEN=16 -> exactly 8 beats counted, no data duplicated or dropped; REQ_DATA_REN[1] stays 0 while req0 is granted.
- ACK delayed 10 cycles, req1 changes REQ_LEN during REQ -> CHNL_TX_LEN keeps the latched value; no REN before ACK.
- RST_N pulsed low mid-XFER -> all outputs 0 asynchronously; after release the next request goes to req0 (rr_ptr=0).
